// File: rtl/opentdc_wb_pkg.sv
// Purpose : Shared definitions for the opentdc Wishbone poller.
//           Holds the register map of the opentdc_wb slave, bus constants
//           and the poller FSM state type.
// Ports   : none (package)
package opentdc_wb_pkg;

  localparam logic [31:0] REG_STATUS_OFF   = 32'h0;
  localparam logic [31:0] REG_TS_OFF       = 32'h4;
  localparam int          STATUS_VALID_BIT = 0;
  localparam logic [3:0]  WB_SEL_ALL       = 4'hF;
  // Writing a one to the valid bit clears it (W1C)
  localparam logic [31:0] STATUS_CLR_DATA  = 32'h1;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_RD_STAT,
    ST_RD_TS,
    ST_CLR,
    ST_ERR
  } poll_state_t;

endpackage

// File: rtl/opentdc_sync_fifo.sv
// Purpose : Single-clock FIFO for captured timestamps.
//           Same-cycle push and pop is supported, including push into a
//           full FIFO while the head is being popped.
// Ports   : clk        clock
//           rst        synchronous reset, active high (empties FIFO)
//           push       write request; ignored when full unless popping
//           push_data  write data
//           pop        read request; ignored when empty
//           pop_data   head entry (zero while empty)
//           full       no free entry
//           empty      no valid entry
module opentdc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/opentdc_wb_poller.sv
// Purpose : Wishbone classic initiator that polls the opentdc_wb slave,
//           reads each captured timestamp, clears its valid flag and
//           streams the timestamps out through a small FIFO.
// Ports   : wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//           enable_i                polling enable
//           wbm_*                   Wishbone classic master port
//           ts_valid_o/ts_data_o    FIFO head, popped by ts_ready_i
//           err_o                   sticky ack-timeout flag
//           ovf_o                   sticky dropped-sample flag
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_WAIT    | idle, counting POLL_CYCLES between status polls
// ST_RD_STAT | reading status register
// ST_RD_TS   | reading timestamp register, push on ack
// ST_CLR     | writing 1 to status bit0 to release the slave
// ST_ERR     | ack timeout seen, bus parked until reset
module opentdc_wb_poller
  import opentdc_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter logic [31:0] STATUS_OFF  = REG_STATUS_OFF,
  parameter logic [31:0] TS_OFF      = REG_TS_OFF,
  parameter int          POLL_CYCLES = 16,
  parameter int          TIMEOUT     = 255,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        ts_valid_o,
  output logic [31:0] ts_data_o,
  input  logic        ts_ready_i,
  output logic        err_o,
  output logic        ovf_o
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);

  poll_state_t state_q, state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          cyc_q, cyc_d, we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic          err_q, err_d, ovf_q, ovf_d;
  logic          ack_ok, push, fifo_full, fifo_empty, fifo_pop;

  // Acks outside our own cycle (stray or late after timeout) are ignored
  assign ack_ok   = cyc_q & wbm_ack_i;
  assign fifo_pop = ts_ready_i & ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    cyc_d      = 1'b0;
    we_d       = 1'b0;
    sel_d      = '0;
    adr_d      = '0;
    dat_d      = '0;

    case (state_q)
      ST_WAIT: begin
        if (enable_i && !err_q) begin
          if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_d = '0;
            state_d    = ST_RD_STAT;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end else begin
          poll_cnt_d = '0;
        end
      end
      ST_RD_STAT: if (ack_ok) state_d = wbm_dat_i[STATUS_VALID_BIT] ? ST_RD_TS : ST_WAIT;
      ST_RD_TS: begin
        if (ack_ok) begin
          push    = 1'b1;
          state_d = ST_CLR;
        end
      end
      ST_CLR:  if (ack_ok) state_d = ST_WAIT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_WAIT;
    endcase

    // Ack wait counter runs down from the cycle the strobe goes out
    if ((state_q inside {ST_RD_STAT, ST_RD_TS, ST_CLR}) && !ack_ok) begin
      if (to_cnt_q == '0) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q - 1'b1;
      end
    end
    if (state_d != state_q) to_cnt_d = TO_LOAD;

    // A push into a full FIFO is dropped unless the head leaves this cycle
    if (push && fifo_full && !fifo_pop) ovf_d = 1'b1;

    // Bus outputs are registered from the next state so they rise on entry
    case (state_d)
      ST_RD_STAT: begin
        cyc_d = 1'b1;
        sel_d = WB_SEL_ALL;
        adr_d = BASE_ADR + STATUS_OFF;
      end
      ST_RD_TS: begin
        cyc_d = 1'b1;
        sel_d = WB_SEL_ALL;
        adr_d = BASE_ADR + TS_OFF;
      end
      ST_CLR: begin
        cyc_d = 1'b1;
        we_d  = 1'b1;
        sel_d = WB_SEL_ALL;
        adr_d = BASE_ADR + STATUS_OFF;
        dat_d = STATUS_CLR_DATA;
      end
      default: cyc_d = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_WAIT;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  opentdc_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (wbm_dat_i),
    .pop       (ts_ready_i),
    .pop_data  (ts_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = we_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign ts_valid_o = ~fifo_empty;
  assign err_o      = err_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_opentdc_wb_poller.sv
// Bench for opentdc_wb_poller: a Wishbone slave model with programmable
// ack delay answers the poller, and a scoreboard of expected timestamps
// is filled when the slave hands a timestamp out and drained when the
// consumer pops the FIFO head.
module tb_opentdc_wb_poller;

  localparam logic [31:0] A_STAT = 32'h3000_0000;
  localparam logic [31:0] A_TS   = 32'h3000_0004;
  localparam int          POLL   = 16;
  localparam int          TMO    = 255;
  localparam int          DEPTH  = 4;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          cyc;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        slv_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slv_dat = 32'hDEAD_BEEF;
  logic        ts_valid, ts_ready = 1'b0;
  logic [31:0] ts_data;
  logic        err, ovf;

  int          cycle_n = 0;
  int          ack_delay = 0;
  bit          never_ack = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] pending[$];
  logic [31:0] exp_q[$];
  bit          exp_ovf = 1'b0;
  acc_t        log_q[$];

  int n_checks = 0;
  int n_pass = 0;

  opentdc_wb_poller dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .enable_i   (enable),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_ack_i  (slv_ack | stray_ack),
    .wbm_dat_i  (slv_dat),
    .ts_valid_o (ts_valid),
    .ts_data_o  (ts_data),
    .ts_ready_i (ts_ready),
    .err_o      (err),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_n++;

  // Slave model: acks after ack_delay waiting cycles; garbage with bit0 set
  // on the data bus whenever it is not acking.
  always @(negedge clk) begin
    slv_ack = 1'b0;
    slv_dat = 32'hDEAD_BEEF;
    if (cyc && stb && !never_ack) begin
      if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        slv_ack  = 1'b1;
        log_q.push_back('{we, sel, adr, dat_o, cycle_n});
        if (we) begin
          if (adr == A_STAT && dat_o[0] && pending.size() > 0) void'(pending.pop_front());
        end else if (adr == A_STAT) begin
          slv_dat = {31'b0, pending.size() > 0};
        end else if (adr == A_TS) begin
          if (pending.size() > 0) begin
            slv_dat = pending[0];
            if (exp_q.size() < DEPTH) exp_q.push_back(pending[0]);
            else exp_ovf = 1'b1;
          end else begin
            slv_dat = 32'hBAD0_0000;
          end
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (cyc && i < 800) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_idle"}, {31'b0, cyc}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    int i = 0;
    while (!ts_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_valid"}, {31'b0, ts_valid}, 32'h1);
    e = 32'hxxxx_xxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_data"}, ts_data, e);
    ts_ready = 1'b1;
    @(negedge clk);
    ts_ready = 1'b0;
  endtask

  initial begin
    int n;
    int i;
    int clr_n;

    // ---- reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", {31'b0, cyc}, 32'h0);
    chk("rst_stb", {31'b0, stb}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_sel", {28'b0, sel}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_valid", {31'b0, ts_valid}, 32'h0);
    chk("rst_data", ts_data, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);

    // ---- status=0: periodic status reads only
    ack_delay = 1;
    log_q.delete();
    enable = 1'b1;
    i = 0;
    while (log_q.size() < 3 && i < 300) begin
      @(negedge clk);
      i++;
    end
    enable = 1'b0;
    chk("poll_count", log_q.size(), 3);
    for (int k = 0; k < log_q.size(); k++) begin
      chk("poll_adr", log_q[k].adr, A_STAT);
      chk("poll_we", {31'b0, log_q[k].we}, 32'h0);
      chk("poll_sel", {28'b0, log_q[k].sel}, 32'hF);
    end
    if (log_q.size() >= 3) begin
      chk("poll_period1", log_q[1].cyc - log_q[0].cyc, POLL + ack_delay + 1);
      chk("poll_period2", log_q[2].cyc - log_q[1].cyc, POLL + ack_delay + 1);
    end
    chk("poll_novalid", {31'b0, ts_valid}, 32'h0);
    wait_idle("poll");
    n = log_q.size();
    repeat (40) @(negedge clk);
    chk("disabled_quiet", log_q.size(), n);

    // ---- one sample, ack delay 2
    ack_delay = 2;
    log_q.delete();
    pending.push_back(32'h0000_1234);
    enable = 1'b1;
    i = 0;
    while (log_q.size() < 3 && i < 300) begin
      @(negedge clk);
      i++;
    end
    enable = 1'b0;
    wait_idle("one");
    chk("one_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("one_rd_stat", log_q[0].adr, A_STAT);
      chk("one_rd_ts", log_q[1].adr, A_TS);
      chk("one_ts_we", {31'b0, log_q[1].we}, 32'h0);
      chk("one_clr_adr", log_q[2].adr, A_STAT);
      chk("one_clr_we", {31'b0, log_q[2].we}, 32'h1);
      chk("one_clr_dat", log_q[2].dat, 32'h1);
    end
    chk("one_ts_const", ts_data, 32'h0000_1234);
    pop_check("one");
    chk("one_empty", {31'b0, ts_valid}, 32'h0);

    // ---- overflow: 5 samples, consumer stalled
    ack_delay = 0;
    log_q.delete();
    for (int k = 1; k <= 5; k++) pending.push_back(32'hA000_0000 + k);
    enable = 1'b1;
    i = 0;
    while (pending.size() > 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    enable = 1'b0;
    wait_idle("ovf");
    clr_n = 0;
    foreach (log_q[k]) if (log_q[k].we && log_q[k].adr == A_STAT && log_q[k].dat == 32'h1) clr_n++;
    chk("ovf_clr_count", clr_n, 5);
    chk("ovf_flag", {31'b0, ovf}, {31'b0, exp_ovf});
    chk("ovf_flag_set", {31'b0, ovf}, 32'h1);
    for (int k = 0; k < DEPTH; k++) pop_check("ovf_pop");
    @(negedge clk);
    chk("ovf_drained", {31'b0, ts_valid}, 32'h0);

    // ---- enable drops while RD_TS waits for ack
    ack_delay = 6;
    log_q.delete();
    pending.push_back(32'h0000_ABCD);
    enable = 1'b1;
    i = 0;
    while (!(cyc && adr == A_TS) && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("en_reached_ts", {31'b0, cyc && adr == A_TS}, 32'h1);
    enable = 1'b0;
    wait_idle("en");
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cyc) n++;
    end
    chk("en_bus_quiet", n, 0);
    chk("en_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("en_ts_done", log_q[1].adr, A_TS);
      chk("en_clr_done", {31'b0, log_q[2].we}, 32'h1);
    end
    pop_check("en");
    log_q.delete();
    enable = 1'b1;
    i = 0;
    while (log_q.size() < 1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("en_resume", log_q.size(), 1);
    enable = 1'b0;
    wait_idle("resume");

    // ---- reset mid-access with data in FIFO and ovf set
    ack_delay = 20;
    log_q.delete();
    pending.push_back(32'h0000_5555);
    enable = 1'b1;
    i = 0;
    while (log_q.size() < 3 && i < 400) begin
      @(negedge clk);
      i++;
    end
    i = 0;
    while (!cyc && i < 100) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    chk("mid_pre_valid", {31'b0, ts_valid}, 32'h1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("mid_cyc", {31'b0, cyc}, 32'h0);
    chk("mid_stb", {31'b0, stb}, 32'h0);
    chk("mid_valid", {31'b0, ts_valid}, 32'h0);
    chk("mid_ovf", {31'b0, ovf}, 32'h0);
    chk("mid_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    pending.delete();
    exp_ovf = 1'b0;
    @(negedge clk);

    // ---- slave never acks
    never_ack = 1'b1;
    enable = 1'b1;
    i = 0;
    while (!cyc && i < 100) begin
      @(negedge clk);
      i++;
    end
    n = 0;
    while (cyc && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", n, TMO);
    chk("to_cyc", {31'b0, cyc}, 32'h0);
    chk("to_stb", {31'b0, stb}, 32'h0);
    chk("to_err", {31'b0, err}, 32'h1);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    never_ack = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cyc) n++;
    end
    chk("to_parked", n, 0);
    chk("to_err_sticky", {31'b0, err}, 32'h1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", {31'b0, err}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
